// File: rtl/slot_alloc_tracker.sv
// Busy-bit tracker for the TX slot pool: round-robin allocator on a valid/ready port,
// release by index with illegal-release flagging, and a registered free-slot count.
module slot_alloc_tracker #(
  parameter int unsigned SLOT_NUM        = 8,
  parameter int unsigned SLOT_ADDR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_alloc_valid,
  output logic                       o_alloc_ready,
  output logic [SLOT_ADDR_WIDTH-1:0] o_alloc_addr,
  input  logic                       i_release_req,
  input  logic [SLOT_ADDR_WIDTH-1:0] i_release_addr,
  output logic [SLOT_NUM-1:0]        o_slot_status,
  output logic [CNT_WIDTH-1:0]       o_free_cnt,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_release_err
);

  localparam logic [SLOT_ADDR_WIDTH-1:0] LAST_IDX  = SLOT_ADDR_WIDTH'(SLOT_NUM - 1);
  localparam logic [CNT_WIDTH-1:0]       FULL_CNT  = CNT_WIDTH'(SLOT_NUM);

  logic [SLOT_NUM-1:0]        r_status;
  logic [SLOT_ADDR_WIDTH-1:0] r_rr_ptr;
  logic [CNT_WIDTH-1:0]       r_free_cnt;
  logic                       r_full;
  logic                       r_empty;
  logic                       r_release_err;

  logic                       w_hi_found;
  logic                       w_lo_found;
  logic [SLOT_ADDR_WIDTH-1:0] w_hi_idx;
  logic [SLOT_ADDR_WIDTH-1:0] w_lo_idx;
  logic [SLOT_ADDR_WIDTH-1:0] w_cand;
  logic                       w_fire;
  logic                       w_in_range;
  logic                       w_rel_busy;
  logic                       w_rel_legal;
  logic                       w_rel_illegal;
  logic [SLOT_NUM-1:0]        w_status_d;
  logic [SLOT_ADDR_WIDTH-1:0] w_rr_ptr_d;
  logic [CNT_WIDTH-1:0]       w_free_cnt_d;

  // Two-segment search: lowest free slot at or above rr_ptr, else lowest free slot below it.
  // Descending iteration lets the last hit (the lowest index) win in each segment.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = SLOT_NUM - 1; i >= 0; i--) begin
      if (!r_status[i]) begin
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SLOT_ADDR_WIDTH'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = SLOT_ADDR_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    if (w_hi_found) begin
      w_cand = w_hi_idx;
    end else if (w_lo_found) begin
      w_cand = w_lo_idx;
    end else begin
      w_cand = r_rr_ptr;
    end
  end

  assign w_fire     = i_alloc_valid & ~r_full;
  assign w_in_range = int'(i_release_addr) < SLOT_NUM;

  always_comb begin
    w_rel_busy = 1'b0;
    if (w_in_range) begin
      w_rel_busy = r_status[i_release_addr];
    end
  end

  assign w_rel_legal   = i_release_req & w_rel_busy;
  assign w_rel_illegal = i_release_req & ~w_rel_busy;

  // Alloc and legal release never target the same slot: candidate is free, release is busy.
  always_comb begin
    w_status_d = r_status;
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (w_fire && (w_cand == SLOT_ADDR_WIDTH'(i))) begin
        w_status_d[i] = 1'b1;
      end
      if (w_rel_legal && (i_release_addr == SLOT_ADDR_WIDTH'(i))) begin
        w_status_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_rr_ptr_d = r_rr_ptr;
    if (w_fire) begin
      w_rr_ptr_d = (w_cand == LAST_IDX) ? '0 : w_cand + 1'b1;
    end
  end

  assign w_free_cnt_d = r_free_cnt - CNT_WIDTH'(w_fire) + CNT_WIDTH'(w_rel_legal);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status      <= '0;
      r_rr_ptr      <= '0;
      r_free_cnt    <= FULL_CNT;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_release_err <= 1'b0;
    end else begin
      r_status      <= w_status_d;
      r_rr_ptr      <= w_rr_ptr_d;
      r_free_cnt    <= w_free_cnt_d;
      r_full        <= (w_free_cnt_d == '0);
      r_empty       <= (w_free_cnt_d == FULL_CNT);
      r_release_err <= w_rel_illegal;
    end
  end

  assign o_alloc_ready = ~r_full;
  assign o_alloc_addr  = w_cand;
  assign o_slot_status = r_status;
  assign o_free_cnt    = r_free_cnt;
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_release_err = r_release_err;

endmodule

// File: tb/tb_slot_alloc_tracker.sv
// Directed bench for slot_alloc_tracker: an 8-slot instance and a 6-slot (non power of two) one.
module tb_slot_alloc_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-slot instance
  logic       a_rst = 1'b1, a_valid = 1'b0, a_rel_req = 1'b0;
  logic [2:0] a_rel_addr = '0;
  logic       a_ready, a_full, a_empty, a_err;
  logic [2:0] a_addr;
  logic [7:0] a_status;
  logic [3:0] a_cnt;

  // 6-slot instance
  logic       b_rst = 1'b1, b_valid = 1'b0, b_rel_req = 1'b0;
  logic [2:0] b_rel_addr = '0;
  logic       b_ready, b_full, b_empty, b_err;
  logic [2:0] b_addr;
  logic [5:0] b_status;
  logic [2:0] b_cnt;

  slot_alloc_tracker #(.SLOT_NUM(8), .SLOT_ADDR_WIDTH(3), .CNT_WIDTH(4)) u_dut_a (
    .clk           (clk),
    .rst           (a_rst),
    .i_alloc_valid (a_valid),
    .o_alloc_ready (a_ready),
    .o_alloc_addr  (a_addr),
    .i_release_req (a_rel_req),
    .i_release_addr(a_rel_addr),
    .o_slot_status (a_status),
    .o_free_cnt    (a_cnt),
    .o_full        (a_full),
    .o_empty       (a_empty),
    .o_release_err (a_err)
  );

  slot_alloc_tracker #(.SLOT_NUM(6), .SLOT_ADDR_WIDTH(3), .CNT_WIDTH(3)) u_dut_b (
    .clk           (clk),
    .rst           (b_rst),
    .i_alloc_valid (b_valid),
    .o_alloc_ready (b_ready),
    .o_alloc_addr  (b_addr),
    .i_release_req (b_rel_req),
    .i_release_addr(b_rel_addr),
    .o_slot_status (b_status),
    .o_free_cnt    (b_cnt),
    .o_full        (b_full),
    .o_empty       (b_empty),
    .o_release_err (b_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Free count must always match the number of zero bits in the status map.
  always @(negedge clk) begin
    if (!a_rst) check("popcnt_a", 64'(a_cnt), 64'(8 - $countones(a_status)));
    if (!b_rst) check("popcnt_b", 64'(b_cnt), 64'(6 - $countones(b_status)));
  end

  task automatic a_reset();
    a_rst = 1'b1; a_valid = 1'b0; a_rel_req = 1'b0;
    tick();
    a_rst = 1'b0;
  endtask

  task automatic a_release(input logic [2:0] addr);
    a_rel_req = 1'b1; a_rel_addr = addr;
    tick();
    a_rel_req = 1'b0;
  endtask

  initial begin
    // ---- Reset state ----
    a_reset();
    check("rst_status", 64'(a_status), 64'h0);
    check("rst_cnt",    64'(a_cnt),    64'd8);
    check("rst_full",   64'(a_full),   64'd0);
    check("rst_empty",  64'(a_empty),  64'd1);
    check("rst_err",    64'(a_err),    64'd0);
    check("rst_ready",  64'(a_ready),  64'd1);
    check("rst_addr",   64'(a_addr),   64'd0);

    // ---- Fill: grants 0..7 on consecutive cycles ----
    a_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fill_addr",  64'(a_addr),  64'(i));
      check("fill_cnt",   64'(a_cnt),   64'(8 - i));
      check("fill_ready", 64'(a_ready), 64'd1);
      tick();
    end
    a_valid = 1'b0;
    check("full_flag",   64'(a_full),   64'd1);
    check("full_ready",  64'(a_ready),  64'd0);
    check("full_status", 64'(a_status), 64'hFF);
    check("full_cnt",    64'(a_cnt),    64'd0);
    check("full_empty",  64'(a_empty),  64'd0);

    // ---- Round-robin reuse ----
    a_release(3'd2);
    check("rr_rel2_status", 64'(a_status), 64'hFB);
    check("rr_rel2_addr",   64'(a_addr),   64'd2);
    a_release(3'd5);
    check("rr_rel5_status", 64'(a_status), 64'hDB);
    check("rr_rel5_cnt",    64'(a_cnt),    64'd2);
    a_valid = 1'b1;
    check("rr_grant1", 64'(a_addr), 64'd2);
    tick();
    check("rr_grant2", 64'(a_addr), 64'd5);
    tick();
    a_valid = 1'b0;
    check("rr_cnt0",  64'(a_cnt),  64'd0);
    check("rr_full",  64'(a_full), 64'd1);
    a_release(3'd2);
    a_valid = 1'b1;
    check("rr_regrant", 64'(a_addr), 64'd2);
    tick();
    a_valid = 1'b0;
    check("rr_refull", 64'(a_status), 64'hFF);

    // ---- Simultaneous alloc + release from status=0F, rr_ptr=4 ----
    a_reset();
    a_valid = 1'b1;
    repeat (4) tick();
    a_valid = 1'b0;
    check("sim_pre_status", 64'(a_status), 64'h0F);
    a_valid = 1'b1; a_rel_req = 1'b1; a_rel_addr = 3'd1;
    check("sim_grant", 64'(a_addr), 64'd4);
    tick();
    a_valid = 1'b0; a_rel_req = 1'b0;
    check("sim_status", 64'(a_status), 64'h1D);
    check("sim_cnt",    64'(a_cnt),    64'd4);
    check("sim_next",   64'(a_addr),   64'd5);

    // ---- Illegal release of free slot 6 ----
    a_release(3'd6);
    check("ill_err",    64'(a_err),    64'd1);
    check("ill_status", 64'(a_status), 64'h1D);
    check("ill_cnt",    64'(a_cnt),    64'd4);
    tick();
    check("ill_err_off", 64'(a_err), 64'd0);

    // ---- Reset mid-operation at status=F3 ----
    a_reset();
    a_valid = 1'b1;
    repeat (8) tick();
    a_valid = 1'b0;
    a_release(3'd2);
    a_release(3'd3);
    check("mid_pre_status", 64'(a_status), 64'hF3);
    a_rst = 1'b1; a_valid = 1'b1; a_rel_req = 1'b1; a_rel_addr = 3'd0;
    tick();
    a_rst = 1'b0; a_valid = 1'b0; a_rel_req = 1'b0;
    check("mid_status", 64'(a_status), 64'h0);
    check("mid_cnt",    64'(a_cnt),    64'd8);
    check("mid_empty",  64'(a_empty),  64'd1);
    check("mid_addr",   64'(a_addr),   64'd0);
    check("mid_err",    64'(a_err),    64'd0);

    // ---- 6-slot instance: wrap and out-of-range release ----
    tick();
    b_rst = 1'b0;
    check("b_rst_cnt",   64'(b_cnt),   64'd6);
    check("b_rst_empty", 64'(b_empty), 64'd1);
    b_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("b_fill_addr", 64'(b_addr), 64'(i));
      tick();
    end
    b_valid = 1'b0;
    check("b_full",   64'(b_full),   64'd1);
    check("b_status", 64'(b_status), 64'h3F);
    b_rel_req = 1'b1; b_rel_addr = 3'd7;
    tick();
    b_rel_req = 1'b0;
    check("b_oor7_err",    64'(b_err),    64'd1);
    check("b_oor7_status", 64'(b_status), 64'h3F);
    b_rel_req = 1'b1; b_rel_addr = 3'd6;
    tick();
    b_rel_req = 1'b0;
    check("b_oor6_err", 64'(b_err), 64'd1);
    b_rel_req = 1'b1; b_rel_addr = 3'd0;
    tick();
    b_rel_req = 1'b0;
    check("b_rel0_err",    64'(b_err),    64'd0);
    check("b_rel0_status", 64'(b_status), 64'h3E);
    b_valid = 1'b1;
    check("b_wrap_grant", 64'(b_addr), 64'd0);
    tick();
    b_valid = 1'b0;
    check("b_wrap_status", 64'(b_status), 64'h3F);
    check("b_wrap_cnt",    64'(b_cnt),    64'd0);
    b_rel_req = 1'b1; b_rel_addr = 3'd3;
    tick();
    b_rel_req = 1'b0;
    // rr_ptr is 1 after granting slot 0, so the only free slot 3 is found.
    check("b_after_addr", 64'(b_addr), 64'd3);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
